// File: rtl/axi4_lite_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave
//
// AXI4-Lite register-file slave holding NUM_REGS registers of DATA_WIDTH bits.
// Write address and write data are accepted independently, in either order,
// and the write commits once both are held. Reads use a two-state FSM with
// one cycle of latency. Out-of-range accesses return SLVERR. A read out of
// range returns zero data.
//
// Parameters
//   ADDRESS_WIDTH : byte-address width
//   DATA_WIDTH    : data width (multiple of 8)
//   NUM_REGS      : number of registers (power of 2, >= 2)
//
// Ports
//   ACLK, ARESET                         clock, synchronous active-high reset
//   S_AXI_AW{ADDR,VALID,READY}           write-address channel
//   S_AXI_W{DATA,STRB,VALID,READY}       write-data channel
//   S_AXI_B{RESP,VALID,READY}            write-response channel
//   S_AXI_AR{ADDR,VALID,READY}           read-address channel
//   S_AXI_R{DATA,RESP,VALID,READY}       read-data channel
// ---------------------------------------------------------------------------
module axi4_lite_slave #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_REGS      = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,

    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,

    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,

    input  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,

    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Register file
    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    // Write-path holding registers
    logic                     aw_held;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic                     w_held;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_W-1:0]        w_strb_q;
    logic                     bvalid_q;
    logic [1:0]               bresp_q;

    // Read-path state
    r_state_t                 r_state;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [1:0]               rresp_q;

    // Write-path decode
    logic                     aw_hs;
    logic                     w_hs;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [ADDRESS_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [STRB_W-1:0]        wr_strb;
    logic [IDX_W-1:0]         wr_idx;
    logic                     wr_oor;

    // Read-path decode
    logic                     ar_hs;
    logic [ADDRESS_WIDTH-1:0] rd_word;
    logic [IDX_W-1:0]         rd_idx;
    logic                     rd_oor;

    // All handshake outputs come straight from registered state.
    assign S_AXI_AWREADY = ~aw_held & ~bvalid_q;
    assign S_AXI_WREADY  = ~w_held  & ~bvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    always_comb begin
        aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
        w_hs    = S_AXI_WVALID  & S_AXI_WREADY;

        // Use the captured half of the transaction if one is already held,
        // otherwise the live channel that is handshaking this cycle.
        wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
        wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
        wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;

        // Commit on the edge where the second half becomes available.
        commit  = (aw_held | aw_hs) & (w_held | w_hs) & ~bvalid_q;

        // Word addressing: low two byte-offset bits are dropped; any set bit
        // above the index field places the access out of range.
        wr_word = wr_addr >> 2;
        wr_idx  = wr_word[IDX_W-1:0];
        wr_oor  = |wr_word[ADDRESS_WIDTH-1:IDX_W];

        ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
        rd_word = S_AXI_ARADDR >> 2;
        rd_idx  = rd_word[IDX_W-1:0];
        rd_oor  = |rd_word[ADDRESS_WIDTH-1:IDX_W];
    end

    // Write path and register file
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
                if (!wr_oor) begin
                    for (int unsigned i = 0; i < STRB_W; i++) begin
                        if (wr_strb[i]) begin
                            regs[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                        end
                    end
                end
            end else if (bvalid_q && S_AXI_BREADY) begin
                // Holding flags stay set through the response so that both
                // READYs remain low until the response has been taken.
                bvalid_q <= 1'b0;
                bresp_q  <= RESP_OKAY;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    // Read path FSM; sampling regs here with non-blocking semantics returns
    // the pre-write value when a write commits on the same edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_DATA;
                        rdata_q <= rd_oor ? '0 : regs[rd_idx];
                        rresp_q <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_state <= R_IDLE;
                        rdata_q <= '0;
                        rresp_q <= RESP_OKAY;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    rdata_q <= '0;
                    rresp_q <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave
//
// Self-checking bench for axi4_lite_slave (default parameters). A behavioural
// register-file model tracks expected contents and responses; directed
// scenarios are followed by randomized reads and writes.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int TMO = 20;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [AW-1:0] S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [DW-1:0] S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [AW-1:0] S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axi4_lite_slave #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .NUM_REGS     (NR)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference: plain array of words
    logic [31:0] mem [NR];

    function automatic void model_clear();
        for (int r = 0; r < NR; r++) mem[r] = 32'h0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        int idx;
        if (addr >= NR * 4) return 2'b10;
        idx = int'(addr >> 2);
        for (int b = 0; b < 4; b++)
            if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [31:0] addr,
                                       output logic [31:0] data,
                                       output logic [1:0] resp);
        if (addr >= NR * 4) begin
            data = 32'h0;
            resp = 2'b10;
        end else begin
            data = mem[int'(addr >> 2)];
            resp = 2'b00;
        end
    endfunction

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Full write transaction; AW and W start after independent delays.
    // lat = cycles waited for BVALID after both handshakes.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat);
        int n;
        fork
            begin
                int k;
                repeat (aw_dly) step();
                S_AXI_AWADDR  = addr;
                S_AXI_AWVALID = 1'b1;
                k = 0;
                while (!S_AXI_AWREADY && k < TMO) begin step(); k++; end
                if (!S_AXI_AWREADY) begin
                    $display("FAIL aw_timeout: AWREADY=%b required 1", S_AXI_AWREADY);
                    miscompares++; vectors++;
                end
                step();
                S_AXI_AWVALID = 1'b0;
            end
            begin
                int k;
                repeat (w_dly) step();
                S_AXI_WDATA  = data;
                S_AXI_WSTRB  = strb;
                S_AXI_WVALID = 1'b1;
                k = 0;
                while (!S_AXI_WREADY && k < TMO) begin step(); k++; end
                if (!S_AXI_WREADY) begin
                    $display("FAIL w_timeout: WREADY=%b required 1", S_AXI_WREADY);
                    miscompares++; vectors++;
                end
                step();
                S_AXI_WVALID = 1'b0;
            end
        join
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < TMO) begin step(); n++; end
        if (!S_AXI_BVALID) begin
            $display("FAIL b_timeout: BVALID=%b required 1", S_AXI_BVALID);
            miscompares++; vectors++;
        end
        lat  = n;
        resp = S_AXI_BRESP;
        step();
        S_AXI_BREADY = 1'b0;
    endtask

    // Full read transaction; lat = cycles waited for RVALID after AR handshake.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < TMO) begin step(); n++; end
        if (!S_AXI_ARREADY) begin
            $display("FAIL ar_timeout: ARREADY=%b required 1", S_AXI_ARREADY);
            miscompares++; vectors++;
        end
        step();
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        n = 0;
        while (!S_AXI_RVALID && n < TMO) begin step(); n++; end
        if (!S_AXI_RVALID) begin
            $display("FAIL r_timeout: RVALID=%b required 1", S_AXI_RVALID);
            miscompares++; vectors++;
        end
        lat  = n;
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        step();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        step();
        step();
        ARESET = 1'b0;
        model_clear();
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            $display("FAIL reset_ready: got %b required 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
            miscompares++;
        end
        vectors++;
        if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
            $display("FAIL reset_valid: got %b required 00", {S_AXI_BVALID, S_AXI_RVALID});
            miscompares++;
        end
        vectors++;
        if ({S_AXI_BRESP, S_AXI_RRESP} !== 4'b0000 || S_AXI_RDATA !== 32'h0) begin
            $display("FAIL reset_data: resp=%b rdata=%h required 0000 / 0",
                     {S_AXI_BRESP, S_AXI_RRESP}, S_AXI_RDATA);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_basic_write_read();
        logic [1:0]  resp, exp_resp;
        logic [31:0] data, exp_data;
        int          lat;
        exp_resp = model_write(32'h04, 32'hDEADBEEF, 4'hF);
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
        if (resp !== exp_resp || lat !== 0) begin
            $display("FAIL basic_bresp: resp=%b lat=%0d required %b / 0", resp, lat, exp_resp);
            miscompares++;
        end
        vectors++;
        model_read(32'h04, exp_data, exp_resp);
        do_read(32'h04, data, resp, lat);
        if (data !== exp_data || resp !== exp_resp || lat !== 0) begin
            $display("FAIL basic_read: data=%h resp=%b lat=%0d required %h / %b / 0",
                     data, resp, lat, exp_data, exp_resp);
            miscompares++;
        end
        vectors++;
        // Zero strobe: register untouched, OKAY
        exp_resp = model_write(32'h04, $urandom, 4'h0);
        do_write(32'h04, $urandom, 4'h0, 1, 0, resp, lat);
        if (resp !== exp_resp) begin
            $display("FAIL strb0_bresp: got %b required %b", resp, exp_resp);
            miscompares++;
        end
        vectors++;
        model_read(32'h04, exp_data, exp_resp);
        do_read(32'h04, data, resp, lat);
        if (data !== exp_data) begin
            $display("FAIL strb0_read: got %h required %h", data, exp_data);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_w_before_aw();
        logic [1:0]  resp, exp_resp;
        logic [31:0] data, exp_data;
        int          lat;
        exp_resp = model_write(32'h08, 32'hAABBCCDD, 4'hF);
        do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, resp, lat);
        S_AXI_BREADY = 1'b1;
        S_AXI_WDATA  = 32'h11223344;
        S_AXI_WSTRB  = 4'h3;
        S_AXI_WVALID = 1'b1;
        step();
        S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
                $display("FAIL wfirst_hold: WREADY=%b AWREADY=%b BVALID=%b required 0/1/0",
                         S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID);
                miscompares++;
            end
            vectors++;
            if (c < 2) step();
        end
        S_AXI_AWADDR  = 32'h08;
        S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        exp_resp = model_write(32'h08, 32'h11223344, 4'h3);
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_resp) begin
            $display("FAIL wfirst_b: BVALID=%b BRESP=%b required 1 / %b",
                     S_AXI_BVALID, S_AXI_BRESP, exp_resp);
            miscompares++;
        end
        vectors++;
        step();
        S_AXI_BREADY = 1'b0;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b110) begin
            $display("FAIL wfirst_release: got %b required 110",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
            miscompares++;
        end
        vectors++;
        model_read(32'h08, exp_data, exp_resp);
        do_read(32'h08, data, resp, lat);
        if (data !== exp_data || data !== 32'hAABB3344) begin
            $display("FAIL wfirst_read: got %h required %h", data, exp_data);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp, exp_resp;
        logic [31:0] data, exp_data;
        int          lat;
        exp_resp = model_write(32'h40, $urandom, 4'hF);
        do_write(32'h40, $urandom, 4'hF, 0, 2, resp, lat);
        if (resp !== exp_resp) begin
            $display("FAIL oor_bresp: got %b required %b", resp, exp_resp);
            miscompares++;
        end
        vectors++;
        for (int r = 0; r < NR; r++) begin
            model_read(32'(r * 4), exp_data, exp_resp);
            do_read(32'(r * 4), data, resp, lat);
            if (data !== exp_data || resp !== exp_resp) begin
                $display("FAIL oor_untouched[%0d]: data=%h resp=%b required %h / %b",
                         r, data, resp, exp_data, exp_resp);
                miscompares++;
            end
            vectors++;
        end
        model_read(32'h40, exp_data, exp_resp);
        do_read(32'h40, data, resp, lat);
        if (data !== exp_data || resp !== exp_resp) begin
            $display("FAIL oor_read: data=%h resp=%b required %h / %b",
                     data, resp, exp_data, exp_resp);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_backpressure();
        logic [1:0]  resp, exp_resp;
        logic [31:0] v, exp_data;
        int          lat;
        v = $urandom | 32'h1;
        exp_resp = model_write(32'h00, v, 4'hF);
        do_write(32'h00, v, 4'hF, 0, 0, resp, lat);
        model_read(32'h00, exp_data, exp_resp);
        S_AXI_ARADDR  = 32'h00;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        step();
        S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_data || S_AXI_ARREADY !== 1'b0) begin
                $display("FAIL r_stall[%0d]: RVALID=%b RDATA=%h ARREADY=%b required 1 / %h / 0",
                         c, S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY, exp_data);
                miscompares++;
            end
            vectors++;
            step();
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 32'h0 || S_AXI_ARREADY !== 1'b1) begin
            $display("FAIL r_idle: RVALID=%b RDATA=%h ARREADY=%b required 0 / 0 / 1",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY);
            miscompares++;
        end
        vectors++;

        v = $urandom;
        exp_resp = model_write(32'h00, v, 4'hF);
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = 32'h00;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = v;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_resp ||
                S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
                $display("FAIL b_stall[%0d]: BVALID=%b BRESP=%b AWREADY=%b WREADY=%b required 1/%b/0/0",
                         c, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY, exp_resp);
                miscompares++;
            end
            vectors++;
            step();
        end
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
            $display("FAIL b_release: got %b required 011",
                     {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_concurrent();
        logic [1:0]  resp, exp_resp;
        logic [31:0] data, exp_old, exp_new;
        int          lat;
        exp_resp = model_write(32'h0C, 32'h5, 4'hF);
        do_write(32'h0C, 32'h5, 4'hF, 0, 0, resp, lat);
        exp_old = mem[3];
        S_AXI_AWADDR  = 32'h0C;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h9;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARADDR  = 32'h0C;
        S_AXI_ARVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        exp_resp = model_write(32'h0C, 32'h9, 4'hF);
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_old || S_AXI_BVALID !== 1'b1) begin
            $display("FAIL concurrent_old: RVALID=%b RDATA=%h BVALID=%b required 1 / %h / 1",
                     S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID, exp_old);
            miscompares++;
        end
        vectors++;
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        model_read(32'h0C, exp_new, exp_resp);
        do_read(32'h0C, data, resp, lat);
        if (data !== exp_new) begin
            $display("FAIL concurrent_new: got %h required %h", data, exp_new);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [31:0] addr, data, exp_data;
        logic [3:0]  strb;
        logic [1:0]  resp, exp_resp;
        int          lat;
        repeat (60) begin
            addr = 32'($urandom_range(0, 'h4F));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                exp_resp = model_write(addr, data, strb);
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
                if (resp !== exp_resp || lat !== 0) begin
                    $display("FAIL rand_write @%h: resp=%b lat=%0d required %b / 0",
                             addr, resp, lat, exp_resp);
                    miscompares++;
                end
                vectors++;
            end else begin
                model_read(addr, exp_data, exp_resp);
                do_read(addr, data, resp, lat);
                if (data !== exp_data || resp !== exp_resp || lat !== 0) begin
                    $display("FAIL rand_read @%h: data=%h resp=%b lat=%0d required %h / %b / 0",
                             addr, data, resp, lat, exp_data, exp_resp);
                    miscompares++;
                end
                vectors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] data, exp_data;
        logic [1:0]  resp, exp_resp;
        int          lat;
        S_AXI_AWADDR  = 32'h14;
        S_AXI_AWVALID = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        if (S_AXI_AWREADY !== 1'b0) begin
            $display("FAIL mid_aw_held: AWREADY=%b required 0", S_AXI_AWREADY);
            miscompares++;
        end
        vectors++;
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        model_clear();
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID} !== 4'b1110) begin
            $display("FAIL mid_reset_state: got %b required 1110",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID});
            miscompares++;
        end
        vectors++;
        for (int r = 0; r < NR; r++) begin
            model_read(32'(r * 4), exp_data, exp_resp);
            do_read(32'(r * 4), data, resp, lat);
            if (data !== exp_data || resp !== exp_resp) begin
                $display("FAIL mid_regs[%0d]: data=%h resp=%b required %h / %b",
                         r, data, resp, exp_data, exp_resp);
                miscompares++;
            end
            vectors++;
        end
    endtask

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        model_clear();

        test_reset();
        test_basic_write_read();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_concurrent();
        test_random();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave.md
AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter NUM_REGS, default 8, number of DATA_WIDTH registers (power of 2, >=2).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 ACLK  in  1  clock; all state changes on rising edge.
REQ-006 ARESET  in  1  synchronous active-high reset.
REQ-007 S_AXI_AWADDR  in  ADDRESS_WIDTH  write address.
REQ-008 S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
REQ-009 S_AXI_WDATA  in  DATA_WIDTH / S_AXI_WSTRB  in  DATA_WIDTH/8  write data and byte strobes.
REQ-010 S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
REQ-011 S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
REQ-012 S_AXI_ARADDR  in  ADDRESS_WIDTH / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
REQ-013 S_AXI_RDATA  out  DATA_WIDTH / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.

Function
REQ-014 Register index SHALL be addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
REQ-015 Address >= NUM_REGS*4 SHALL be out of range: response SLVERR (2'b10), no register write, RDATA = 0; in-range response OKAY (2'b00).
REQ-016 Write path: AW and W SHALL be accepted independently, in either order or the same cycle; each captured into a holding register on its handshake.
REQ-017 AWREADY SHALL be 1 iff no address is held and BVALID=0; WREADY SHALL be 1 iff no data is held and BVALID=0.
REQ-018 On the edge where both address and data become held (live or previously captured), the target register SHALL be updated for each byte lane with WSTRB[i]=1, and BVALID SHALL go 1 the following cycle with BRESP set.
REQ-019 WSTRB = 0 to an in-range address SHALL leave the register unchanged and return OKAY.
REQ-020 BVALID/BRESP SHALL hold stable until BREADY=1; on that edge BVALID drops, holding flags clear, AWREADY/WREADY return to 1 the next cycle.
REQ-021 A second AW (or W) arriving while the first is held SHALL be back-pressured (READY=0) until the response completes.
REQ-022 Read path states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-023 R_IDLE -> R_DATA on ARVALID&ARREADY; RDATA/RRESP registered on that edge, latency 1 cycle.
REQ-024 R_DATA -> R_IDLE on RVALID&RREADY; RDATA/RRESP stable while RVALID=1 and RREADY=0.
REQ-025 Read and write paths SHALL operate concurrently; a read sampling the same register on the write-commit edge SHALL return the pre-write value.
REQ-026 Outputs SHALL depend only on registered state (no combinational VALID/READY from inputs).
REQ-027 In R_IDLE, RDATA SHALL be 0.

Reset
REQ-028 ARESET=1 at a rising edge SHALL clear all registers to 0, clear holding flags, enter R_IDLE; AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0 from the next cycle.
REQ-029 Reset mid-transaction SHALL abandon it with no register write and no response.

Verification
REQ-030 AW(0x04) and W(0xDEADBEEF, strb 0xF) same cycle -> BVALID next cycle, BRESP=00; read 0x04 -> RDATA=0xDEADBEEF one cycle after AR handshake.
REQ-031 W(0x11223344, strb 0x3) 3 cycles before AW(0x08), reg held 0xAABBCCDD -> WREADY drops after W handshake; reg becomes 0xAABB3344.
REQ-032 Write 0x40 (NUM_REGS=8) -> BRESP=10, no register changes; read 0x40 -> RRESP=10, RDATA=0.
REQ-033 RREADY held 0 for 4 cycles after read of 0x00 -> RVALID=1 and RDATA stable all 4 cycles, ARREADY=0; BREADY=0 likewise holds BVALID and keeps AWREADY=WREADY=0.
REQ-034 Simultaneous read and write to 0x0C (old 0x5, new 0x9) -> read returns 0x5, subsequent read 0x9.
REQ-035 ARESET asserted after AW handshake, before W -> all READY=1, no write, registers 0.
